for_loop_sweep_ctrl: RTL

FOR_LOOP_SWEEP_CTRL -- requirements
Module: for_loop_sweep_ctrl

---
 rtl/for_loop_sweep_ctrl.sv | 95 +++++++++
 1 files changed

// File: rtl/for_loop_sweep_ctrl.sv
// Exhaustive input sweep: drives every dut_in value, waits SETTLE cycles, captures dut_out, folds it into a signature.
// Costs SETTLE+1 cycles per vector; no backpressure, and abort or rst returns the block to IDLE on the next edge.
module for_loop_sweep_ctrl #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [WIDTH-1:0] dut_in,
  input  logic [WIDTH-1:0] dut_out,
  output logic             busy,
  output logic             cap_valid,
  output logic [WIDTH-1:0] cap_idx,
  output logic [WIDTH-1:0] cap_data,
  output logic             done,
  output logic [WIDTH-1:0] signature
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CAPTURE,
    S_DONE
  } state_t;

  localparam logic [7:0]       SETTLE_LD = 8'(SETTLE - 1);
  localparam logic [WIDTH-1:0] ALL_ONES  = '1;

  state_t           state, state_nx;
  logic [7:0]       cnt, cnt_nx;
  logic [WIDTH-1:0] dut_in_nx, sig_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      dut_in    <= '0;
      signature <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      dut_in    <= dut_in_nx;
      signature <= sig_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    dut_in_nx = dut_in;
    sig_nx    = signature;
    // abort wins over every in-sweep transition, including the capture fold
    if (abort && state != S_IDLE) begin
      state_nx  = S_IDLE;
      cnt_nx    = '0;
      dut_in_nx = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            state_nx  = S_SETTLE;
            cnt_nx    = SETTLE_LD;
            dut_in_nx = '0;
            sig_nx    = '0;
          end
        end
        S_SETTLE: begin
          if (cnt != 8'd0) cnt_nx = cnt - 8'd1;
          else             state_nx = S_CAPTURE;
        end
        S_CAPTURE: begin
          sig_nx = {signature[WIDTH-2:0], signature[WIDTH-1]} ^ dut_out;
          if (dut_in == ALL_ONES) begin
            state_nx = S_DONE;
          end else begin
            state_nx  = S_SETTLE;
            cnt_nx    = SETTLE_LD;
            dut_in_nx = dut_in + 1'b1;
          end
        end
        S_DONE:  state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  assign busy      = (state == S_SETTLE) || (state == S_CAPTURE);
  assign cap_valid = (state == S_CAPTURE);
  assign cap_idx   = cap_valid ? dut_in  : '0;
  assign cap_data  = cap_valid ? dut_out : '0;
  assign done      = (state == S_DONE);

endmodule
